oq_remove_sched: RTL and testbench

- Remove-side scheduler for the SRAM output queues in the packet-generator output-queue subsystem.
- Consumes the per-queue empty vector produced by the empty evaluator.
- Picks a non-empty, enabled queue whose MAC can accept a packet, using round robin, and commands the remove datapath to read one packet.
- When the packet is done, issues the src_update notification, then holds that queue until its empty status has been re-evaluated.

---
 rtl/oq_sched_pkg.sv | 23 ++
 rtl/oq_rr_pick.sv | 32 +++
 rtl/oq_remove_sched.sv | 128 ++++++++++++
 tb/tb_oq_remove_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oq_sched_pkg.sv
// Shared types and helpers for the output-queue
// remove-side scheduler.
package oq_sched_pkg;

  localparam int DEF_EVAL_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    XFER      = 3'd2,
    UPDATE    = 3'd3,
    WAIT_EVAL = 3'd4
  } oq_state_e;

  function automatic int oq_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/oq_rr_pick.sv
// Round-robin pick: rotate eligibility to the pointer,
// take the lowest set bit, rotate the index back.
module oq_rr_pick
  import oq_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int W = oq_log2(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] rr_ptr,
  output logic         found,
  output logic [W-1:0] index
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  // rotate, priority-encode, rotate back
  always_comb begin
    rot   = N'({elig, elig} >> rr_ptr);
    found = |rot;
    off   = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = W'(i);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (W+1)'(N))
      sum = sum - (W+1)'(N);
    index = sum[W-1:0];
  end

endmodule

// File: rtl/oq_remove_sched.sv
// Remove-side scheduler: one packet at a time from a
// round-robin chosen queue, then wait for re-evaluation.
module oq_remove_sched
  import oq_sched_pkg::*;
#(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_OQ_WIDTH = oq_log2(NUM_OUTPUT_QUEUES),
  parameter int EVAL_TIMEOUT = DEF_EVAL_TIMEOUT,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_OUTPUT_QUEUES-1:0] empty,
  input  logic [NUM_OUTPUT_QUEUES-1:0] enable,
  input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
  output logic                         rm_req,
  output logic [NUM_OQ_WIDTH-1:0]      rm_oq,
  input  logic                         rm_ack,
  input  logic                         rm_done,
  output logic                         src_update,
  output logic [NUM_OQ_WIDTH-1:0]      src_oq,
  input  logic                         eval_done,
  output logic                         busy,
  output logic                         eval_timeout_err,
  output logic [CNT_WIDTH-1:0]         pkt_cnt
);

  localparam int TO_W = oq_log2(EVAL_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX =
    TO_W'(EVAL_TIMEOUT - 1);
  localparam logic [NUM_OQ_WIDTH-1:0] LAST =
    NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);

  oq_state_e                  state;
  logic [NUM_OQ_WIDTH-1:0]    rr_ptr;
  logic [NUM_OQ_WIDTH-1:0]    rr_nxt;
  logic [NUM_OQ_WIDTH-1:0]    pick;
  logic [NUM_OUTPUT_QUEUES-1:0] elig;
  logic [TO_W-1:0]            to_cnt;
  logic                       found;
  logic                       finish;
  logic                       lost;

  assign elig = enable & ~empty & out_rdy;

  oq_rr_pick #(
    .N (NUM_OUTPUT_QUEUES),
    .W (NUM_OQ_WIDTH)
  ) u_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .found  (found),
    .index  (pick)
  );

  // packet finished this cycle, either path
  always_comb begin
    finish = 1'b0;
    if (state == REQ)
      finish = rm_ack && rm_done;
    else if (state == XFER)
      finish = rm_done;
  end

  assign lost   = empty[rm_oq] || !enable[rm_oq];
  assign rr_nxt = (rm_oq == LAST) ? '0 : rm_oq + 1'b1;
  assign busy   = (state != IDLE);

  // scheduler state, handshake and bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      rm_req           <= 1'b0;
      rm_oq            <= '0;
      src_update       <= 1'b0;
      src_oq           <= '0;
      eval_timeout_err <= 1'b0;
      pkt_cnt          <= '0;
      to_cnt           <= '0;
    end else begin
      src_update <= 1'b0;
      if (finish) begin
        src_update <= 1'b1;
        src_oq     <= rm_oq;
        pkt_cnt    <= pkt_cnt + 1'b1;
        rr_ptr     <= rr_nxt;
      end
      unique case (state)
        IDLE: begin
          if (found) begin
            rm_oq  <= pick;
            rm_req <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (rm_ack) begin
            rm_req <= 1'b0;
            state  <= rm_done ? UPDATE : XFER;
          end else if (lost) begin
            rm_req <= 1'b0;
            state  <= IDLE;
          end
        end
        XFER: begin
          if (rm_done) state <= UPDATE;
        end
        UPDATE: begin
          to_cnt <= '0;
          state  <= WAIT_EVAL;
        end
        WAIT_EVAL: begin
          if (eval_done) begin
            state <= IDLE;
          end else if (to_cnt == TO_MAX) begin
            eval_timeout_err <= 1'b1;
            state            <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oq_remove_sched.sv
// Scoreboard bench for oq_remove_sched with a
// queue-level round-robin reference model.
module tb_oq_remove_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] empty = 8'hFF;
  logic [7:0] enable = 8'h00;
  logic [7:0] out_rdy = 8'h00;
  logic       rm_ack = 1'b0;
  logic       rm_done = 1'b0;
  logic       eval_done = 1'b0;
  logic       rm_req;
  logic [2:0] rm_oq;
  logic       src_update;
  logic [2:0] src_oq;
  logic       busy;
  logic       eval_timeout_err;
  logic [31:0] pkt_cnt;

  oq_remove_sched dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .empty            (empty),
    .enable           (enable),
    .out_rdy          (out_rdy),
    .rm_req           (rm_req),
    .rm_oq            (rm_oq),
    .rm_ack           (rm_ack),
    .rm_done          (rm_done),
    .src_update       (src_update),
    .src_oq           (src_oq),
    .eval_done        (eval_done),
    .busy             (busy),
    .eval_timeout_err (eval_timeout_err),
    .pkt_cnt          (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int cnt;
  } upd_t;

  int   tests = 0;
  int   fails = 0;
  int   m_ptr = 0;
  int   m_cnt = 0;
  int   m_err = 0;
  int   req_q[$];
  upd_t upd_q[$];
  bit   prev_req = 1'b0;

  task automatic chk(input string name,
                     input longint act,
                     input longint want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, want);
    end
  endtask

  // first eligible queue at or after ptr, cyclic
  function automatic int model_pick(input logic [7:0] el,
                                    input int ptr);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (ptr + k) % 8;
      if (el[i]) return i;
    end
    return -1;
  endfunction

  // monitor: pop expectations on DUT events
  always @(negedge clk) begin
    if (reset_n) begin
      if (rm_req && !prev_req) begin
        if (req_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_req: unexpected rm_req oq=%0d",
                   rm_oq);
        end else begin
          int e;
          e = req_q.pop_front();
          chk("sb_rm_oq", rm_oq, e);
        end
      end
      if (src_update) begin
        if (upd_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_upd: unexpected src_update oq=%0d",
                   src_oq);
        end else begin
          upd_t u;
          u = upd_q.pop_front();
          chk("sb_src_oq", src_oq, u.q);
          chk("sb_pkt_cnt", pkt_cnt, u.cnt);
        end
      end
    end
    prev_req = rm_req;
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    rm_ack    = 1'b0;
    rm_done   = 1'b0;
    eval_done = 1'b0;
    #1;
    chk("rst_rm_req", rm_req, 0);
    chk("rst_rm_oq", rm_oq, 0);
    chk("rst_src_update", src_update, 0);
    chk("rst_src_oq", src_oq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", eval_timeout_err, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    m_ptr = 0;
    m_cnt = 0;
    m_err = 0;
    @(negedge clk);
  endtask

  // one full packet; called at a negedge with DUT idle
  task automatic do_pkt(input logic [7:0] e,
                        input logic [7:0] en,
                        input logic [7:0] r,
                        input int ackd,
                        input int doned,
                        input int evald,
                        input bit withhold,
                        input bit scramble,
                        input logic [7:0] drop_en);
    int exp_q;
    int n;
    empty   = e;
    enable  = en;
    out_rdy = r;
    reset_n = 1'b1;
    exp_q = model_pick(en & ~e & r, m_ptr);
    req_q.push_back(exp_q);
    @(negedge clk);
    chk("req_latency", rm_req, 1);
    repeat (ackd) @(negedge clk);
    chk("req_hold", rm_req, 1);
    rm_ack  = 1'b1;
    rm_done = (doned == 0);
    m_cnt++;
    m_ptr = (exp_q + 1) % 8;
    upd_q.push_back('{exp_q, m_cnt});
    @(negedge clk);
    rm_ack  = 1'b0;
    rm_done = 1'b0;
    chk("ack_drops_req", rm_req, 0);
    enable = enable & ~drop_en;
    if (scramble) begin
      empty   = 8'($urandom);
      enable  = 8'($urandom);
      out_rdy = 8'($urandom);
    end
    if (doned > 0) begin
      repeat (doned - 1) @(negedge clk);
      rm_done = 1'b1;
      @(negedge clk);
      rm_done = 1'b0;
    end
    chk("upd_latency", src_update, 1);
    if (!withhold) begin
      repeat (evald) @(negedge clk);
      chk("err_state", eval_timeout_err, m_err);
      eval_done = 1'b1;
      @(negedge clk);
      eval_done = 1'b0;
      chk("idle_after_eval", busy, 0);
    end else begin
      n = 0;
      while (busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_cycles", n, 16);
      chk("timeout_err", eval_timeout_err, 1);
      m_err = 1;
    end
  endtask

  initial begin
    int exp_q;
    int n;
    int k;
    logic [7:0] e, en, r;

    @(negedge clk);
    do_reset();
    do_pkt(8'hFB, 8'hFF, 8'hFF, 1, 5, 2, 0, 0, 8'h00);

    do_reset();
    for (int i = 0; i < 5; i++)
      do_pkt(8'hB5, 8'hFF, 8'hFF, i % 3, 2, 1, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++)
      do_pkt(8'h7E, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'h00);

    empty   = 8'hEF;
    enable  = 8'hFF;
    out_rdy = 8'hFF;
    exp_q = model_pick(enable & ~empty & out_rdy, m_ptr);
    req_q.push_back(exp_q);
    @(negedge clk);
    chk("abort_req", rm_req, 1);
    @(negedge clk);
    empty = 8'hFF;
    @(negedge clk);
    chk("abort_drop", rm_req, 0);
    chk("abort_idle", busy, 0);
    chk("abort_cnt", pkt_cnt, m_cnt);
    do_pkt(8'hB7, 8'hFF, 8'hFF, 1, 2, 1, 0, 0, 8'h00);

    do_pkt(8'hDF, 8'hFF, 8'hFF, 0, 0, 1, 1, 0, 8'h00);

    empty   = 8'h00;
    enable  = 8'hFF;
    out_rdy = 8'h00;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (rm_req || busy) n++;
    end
    chk("gate_no_req", n, 0);
    do_pkt(8'h00, 8'hFF, 8'h20, 1, 3, 2, 0, 0, 8'h20);

    for (int i = 0; i < 40; i++) begin
      k = 0;
      do begin
        e  = 8'($urandom);
        en = 8'($urandom);
        r  = 8'($urandom);
        k++;
      end while (((en & ~e & r) == 8'h00) && k < 50);
      if ((en & ~e & r) == 8'h00) begin
        e  = 8'hFE;
        en = 8'hFF;
        r  = 8'hFF;
      end
      do_pkt(e, en, r,
             $urandom_range(0, 3),
             $urandom_range(0, 4),
             $urandom_range(1, 3),
             0, 1'($urandom_range(0, 1)), 8'h00);
    end

    empty   = 8'h00;
    enable  = 8'hFF;
    out_rdy = 8'hFF;
    exp_q = model_pick(enable & ~empty & out_rdy, m_ptr);
    req_q.push_back(exp_q);
    @(negedge clk);
    chk("async_req", rm_req, 1);
    rm_ack = 1'b1;
    @(negedge clk);
    rm_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("xfer_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rm_req", rm_req, 0);
    chk("async_busy", busy, 0);
    chk("async_pkt_cnt", pkt_cnt, 0);
    empty  = 8'hFF;
    enable = 8'h00;
    m_ptr = 0;
    m_cnt = 0;
    m_err = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", busy, 0);
    chk("post_reset_err", eval_timeout_err, 0);

    chk("sb_req_drain", req_q.size(), 0);
    chk("sb_upd_drain", upd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
